// File: rtl/imem_pkg.sv
// Shared constants and loader state encoding for the instruction memory
// and its upstream byte-stream loader.
package imem_pkg;

  localparam int IMEM_DEPTH  = 64;
  localparam int IMEM_WORD_W = 16;
  localparam int IMEM_BYTE_W = 8;
  localparam logic [IMEM_WORD_W-1:0] IMEM_NOP = 16'h0000;

  // Loader FSM states; exposed on the loader's dbg_state port.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RECV_HI = 3'd1,
    ST_RECV_LO = 3'd2,
    ST_PAD     = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_DONE    = 3'd5
  } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction-memory shift register.
// Assembles big-endian words from a valid/ready byte stream, issues one
// registered shift pulse per word, pads with PAD_WORD until exactly DEPTH
// shifts have been issued, then pulses done.
//
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready.
// in_ready is a registered function of the FSM state only (high in RECV_HI,
// RECV_LO and DRAIN); in_data/in_last are only looked at on a transfer, and
// in_valid may drop at any cycle without losing data.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int WORD_W = IMEM_WORD_W,
  parameter int BYTE_W = IMEM_BYTE_W,
  parameter logic [WORD_W-1:0] PAD_WORD = IMEM_NOP,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  output logic              shift_enable,
  output logic [WORD_W-1:0] new_value,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  word_count,
  output logic [2:0]        dbg_state
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_WORD_C = CNT_W'(DEPTH - 1);

  loader_state_e     state_q;
  logic [BYTE_W-1:0] hi_q;
  logic              in_ready_q;
  logic              shift_enable_q;
  logic [WORD_W-1:0] new_value_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic [CNT_W-1:0]  word_count_q;

  // Loader FSM with byte latch, shift counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      hi_q           <= '0;
      in_ready_q     <= 1'b0;
      shift_enable_q <= 1'b0;
      new_value_q    <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      word_count_q   <= '0;
    end else begin
      // Pulses default low; branches below raise them for one cycle.
      shift_enable_q <= 1'b0;
      done_q         <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q      <= ST_RECV_HI;
            word_count_q <= '0;
            error_q      <= 1'b0;
            busy_q       <= 1'b1;
            in_ready_q   <= 1'b1;
          end
        end

        ST_RECV_HI: begin
          if (in_valid) begin
            hi_q <= in_data;
            if (in_last) begin
              // Odd-length program: complete the word with a zero low byte.
              shift_enable_q <= 1'b1;
              new_value_q    <= {in_data, {BYTE_W{1'b0}}};
              word_count_q   <= word_count_q + 1'b1;
              error_q        <= 1'b1;
              in_ready_q     <= 1'b0;
              state_q        <= ST_PAD;
            end else begin
              state_q <= ST_RECV_LO;
            end
          end
        end

        ST_RECV_LO: begin
          if (in_valid) begin
            shift_enable_q <= 1'b1;
            new_value_q    <= {hi_q, in_data};
            word_count_q   <= word_count_q + 1'b1;
            if (in_last) begin
              // PAD issues zero shifts when this was word DEPTH.
              in_ready_q <= 1'b0;
              state_q    <= ST_PAD;
            end else if (word_count_q == LAST_WORD_C) begin
              // Memory full but the stream continues: swallow the rest.
              error_q <= 1'b1;
              state_q <= ST_DRAIN;
            end else begin
              state_q <= ST_RECV_HI;
            end
          end
        end

        ST_PAD: begin
          if (word_count_q < DEPTH_C) begin
            shift_enable_q <= 1'b1;
            new_value_q    <= PAD_WORD;
            word_count_q   <= word_count_q + 1'b1;
          end else begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end
        end

        ST_DRAIN: begin
          if (in_valid && in_last) begin
            in_ready_q <= 1'b0;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= ST_DONE;
          end
        end

        ST_DONE: begin
          // done is high during this cycle; a start here is not honoured.
          state_q <= ST_IDLE;
        end

        default: begin
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign shift_enable = shift_enable_q;
  assign new_value    = new_value_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign word_count   = word_count_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: drives byte programs (with and without gaps),
// keeps a downstream IMEM image, and compares against a program-level model.
module tb_imem_loader;
  import imem_pkg::*;

  localparam int DEPTH = 64;
  localparam int CW    = 7;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        shift_enable;
  logic [15:0] new_value;
  logic        busy;
  logic        done;
  logic        error;
  logic [CW-1:0] word_count;
  logic [2:0]  dbg_state;

  imem_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .shift_enable (shift_enable),
    .new_value    (new_value),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .word_count   (word_count),
    .dbg_state    (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // stimulus program and expected shift sequence
  logic [7:0]  tx_q[$];
  logic [15:0] exp_q[$];
  logic        exp_err;

  // observed downstream side
  logic [15:0] imem[DEPTH];
  logic [15:0] obs_q[$];
  int          shift_cyc_q[$];
  int          done_cnt;
  int          done_cyc;
  int          start_cyc;
  logic        busy_at_start;

  always @(posedge clk) cyc++;

  // IMEM model plus shift/done recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) imem[k] = 16'h0;
    end else begin
      if (shift_enable) begin
        for (int k = DEPTH - 1; k > 0; k--) imem[k] = imem[k-1];
        imem[0] = new_value;
        obs_q.push_back(new_value);
        shift_cyc_q.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Program-level model: big-endian pairs, zero low byte for an odd tail,
  // truncate to DEPTH words, pad with NOP up to DEPTH.
  task automatic build_exp();
    int n, nw;
    logic [7:0] lo;
    exp_q.delete();
    n  = tx_q.size();
    nw = (n + 1) / 2;
    exp_err = (n % 2 == 1) || (nw > DEPTH);
    for (int w = 0; w < nw && w < DEPTH; w++) begin
      lo = (2*w + 1 < n) ? tx_q[2*w+1] : 8'h00;
      exp_q.push_back({tx_q[2*w], lo});
    end
    while (exp_q.size() < DEPTH) exp_q.push_back(16'h0000);
  endtask

  task automatic fill_random(input int nbytes);
    tx_q.delete();
    for (int i = 0; i < nbytes; i++) tx_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Driver: start pulse, then the bytes of tx_q with optional gaps and stray
  // start pulses; waits for done when the program carries a last byte.
  task automatic run_load(input bit gaps, input bit mid_start, input bit has_last);
    int idx, guard;
    bit hs;
    obs_q.delete();
    shift_cyc_q.delete();
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    busy_at_start = busy;
    idx = 0;
    guard = 0;
    while (idx < tx_q.size() && guard < 4000) begin
      in_valid = !(gaps && $urandom_range(0, 3) == 0);
      in_data  = tx_q[idx];
      in_last  = has_last && (idx == tx_q.size() - 1);
      if (mid_start) start = ($urandom_range(0, 7) == 0);
      hs = in_valid && in_ready;
      @(negedge clk);
      if (hs) idx++;
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    start    = 1'b0;
    if (idx < tx_q.size()) begin
      checks++; errors++;
      $display("FAIL byte_accept_timeout: accepted %0d bytes, required %0d", idx, tx_q.size());
    end
    if (has_last) begin
      guard = 0;
      while (done_cnt == 0 && guard < 400) begin
        @(negedge clk);
        guard++;
      end
      if (done_cnt == 0) begin
        checks++; errors++;
        $display("FAIL done_timeout: no done within 400 cycles");
      end
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, shift_enable, busy, done, error} !== 5'b0 || new_value !== 16'h0 ||
        word_count !== '0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_values: rdy=%b se=%b nv=%h busy=%b done=%b err=%b wc=%0d st=%0d, required all zero/IDLE",
               in_ready, shift_enable, new_value, busy, done, error, word_count, dbg_state);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: rdy=%b busy=%b, required 0 0", in_ready, busy);
    end
  endtask

  task automatic test_full_load();
    int bad;
    tx_q.delete();
    for (int i = 0; i < 128; i++) tx_q.push_back(8'(i));
    build_exp();
    run_load(1'b0, 1'b0, 1'b1);
    checks++;
    if (busy_at_start !== 1'b1) begin
      errors++; $display("FAIL full_busy: got %b required 1", busy_at_start);
    end
    checks++;
    if (obs_q.size() != DEPTH) begin
      errors++; $display("FAIL full_shift_count: got %0d required %0d", obs_q.size(), DEPTH);
    end
    bad = 0;
    for (int i = 0; i < DEPTH && i < obs_q.size(); i++) if (obs_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL full_shift_values: %0d words differ from model", bad);
    end
    checks++;
    if (imem[63] !== 16'h0001 || imem[0] !== 16'h7E7F) begin
      errors++; $display("FAIL full_imem_ends: imem63=%h imem0=%h required 0001 7e7f", imem[63], imem[0]);
    end
    checks++;
    if (error !== 1'b0 || done_cnt != 1 || word_count !== CW'(DEPTH) || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_status: err=%b done_cnt=%0d wc=%0d busy=%b required 0 1 64 0", error, done_cnt, word_count, busy);
    end
    checks++;
    if (done_cyc - start_cyc != 130) begin
      errors++; $display("FAIL full_done_latency: got %0d cycles required 130", done_cyc - start_cyc);
    end
  endtask

  task automatic test_short_program();
    int bad;
    tx_q = '{8'hA0, 8'h01, 8'hA0, 8'h02, 8'hA0, 8'h03};
    build_exp();
    run_load(1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_q.size() != DEPTH) begin
      errors++; $display("FAIL short_shift_count: got %0d required %0d", obs_q.size(), DEPTH);
    end
    checks++;
    if (imem[63] !== 16'hA001 || imem[62] !== 16'hA002 || imem[61] !== 16'hA003) begin
      errors++; $display("FAIL short_data_words: %h %h %h required a001 a002 a003", imem[63], imem[62], imem[61]);
    end
    bad = 0;
    for (int i = 0; i <= 60; i++) if (imem[i] !== 16'h0000) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL short_pad_words: %0d pad entries nonzero, required 0", bad);
    end
    checks++;
    if (shift_cyc_q.size() == DEPTH && shift_cyc_q[63] - shift_cyc_q[3] != 60) begin
      errors++; $display("FAIL short_pad_back_to_back: span %0d cycles required 60", shift_cyc_q[63] - shift_cyc_q[3]);
    end
    checks++;
    if (error !== 1'b0 || done_cnt != 1 || word_count !== CW'(DEPTH)) begin
      errors++; $display("FAIL short_status: err=%b done_cnt=%0d wc=%0d required 0 1 64", error, done_cnt, word_count);
    end
  endtask

  task automatic test_odd_length();
    int bad;
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    build_exp();
    run_load(1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_q.size() != DEPTH || obs_q[2] !== 16'h5500) begin
      errors++; $display("FAIL odd_tail_word: count=%0d word2=%h required 64 5500", obs_q.size(), obs_q.size() > 2 ? obs_q[2] : 16'hxxxx);
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (imem[DEPTH-1-i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL odd_imem: %0d entries differ from model", bad);
    end
    checks++;
    if (error !== 1'b1 || done_cnt != 1) begin
      errors++; $display("FAIL odd_status: err=%b done_cnt=%0d required 1 1", error, done_cnt);
    end
  endtask

  task automatic test_overflow();
    int bad;
    fill_random(130);
    build_exp();
    run_load(1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_q.size() != DEPTH) begin
      errors++; $display("FAIL overflow_shift_count: got %0d required %0d", obs_q.size(), DEPTH);
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (imem[DEPTH-1-i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL overflow_imem: %0d entries differ from model", bad);
    end
    checks++;
    if (error !== 1'b1 || done_cnt != 1 || word_count !== CW'(DEPTH)) begin
      errors++; $display("FAIL overflow_status: err=%b done_cnt=%0d wc=%0d required 1 1 64", error, done_cnt, word_count);
    end
  endtask

  task automatic test_gaps_random();
    int bad, nb;
    for (int r = 0; r < 5; r++) begin
      nb = (r == 0) ? 128 : $urandom_range(1, 140);
      fill_random(nb);
      build_exp();
      run_load(1'b1, 1'b1, 1'b1);
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (imem[DEPTH-1-i] !== exp_q[i]) bad++;
      checks++;
      if (obs_q.size() != DEPTH || bad != 0) begin
        errors++; $display("FAIL gaps_imem[%0d]: len=%0d shifts=%0d diffs=%0d required 64 0", r, nb, obs_q.size(), bad);
      end
      checks++;
      if (error !== exp_err || done_cnt != 1) begin
        errors++; $display("FAIL gaps_status[%0d]: len=%0d err=%b done_cnt=%0d required %b 1", r, nb, error, done_cnt, exp_err);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int bad;
    fill_random(20);
    run_load(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, shift_enable, busy, done, error} !== 5'b0 || new_value !== 16'h0 ||
        word_count !== '0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL midreset_values: rdy=%b se=%b nv=%h busy=%b done=%b err=%b wc=%0d st=%0d, required all zero/IDLE",
               in_ready, shift_enable, new_value, busy, done, error, word_count, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (imem[i] !== 16'h0) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL midreset_imem_cleared: %0d entries nonzero", bad);
    end
    fill_random(128);
    build_exp();
    run_load(1'b1, 1'b0, 1'b1);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (imem[DEPTH-1-i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || error !== 1'b0 || done_cnt != 1) begin
      errors++; $display("FAIL midreset_reload: diffs=%0d err=%b done_cnt=%0d required 0 0 1", bad, error, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_short_program();
    test_odd_length();
    test_overflow();
    test_gaps_random();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Upstream feeder for the 64×16 instruction-memory shift register. Accepts a program as a byte stream over a valid/ready handshake and assembles big-endian 16-bit words. For each word it drives one `shift_enable` pulse with `new_value`. After the stream ends, it shifts in pad words until exactly DEPTH shifts have been issued, so the first received word always lands at IMEM[DEPTH-1], and it signals completion.

## Interface
Parameters:
- DEPTH, 64: IMEM entries; total shifts issued per load.
- WORD_W, 16: instruction width; equals IMEM `new_value` width.
- BYTE_W, 8: input byte width; WORD_W = 2×BYTE_W.
- PAD_WORD, 16'h0000: word shifted in after stream end (NOP).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin load. Honoured only in IDLE; ignored otherwise.
- in_valid  in  1  byte valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- in_data  in  BYTE_W  stream byte.
- in_last  in  1  final byte of program, qualified by handshake.
- shift_enable  out  1  one-cycle shift pulse to IMEM, registered.
- new_value  out  WORD_W  word to insert at IMEM[0]. Valid while shift_enable=1.
- busy  out  1  high from start accept until done.
- done  out  1  one-cycle pulse when load finishes.
- error  out  1  sticky. Cleared on next accepted start.
- word_count  out  $clog2(DEPTH+1)  shifts issued in current load, including pad.

## Operation
- Reset values: in_ready=0, shift_enable=0, new_value=0, busy=0, done=0, error=0, word_count=0, state=IDLE.
- States:
  - IDLE: on start → RECV_HI; word_count←0, error←0, busy←1.
  - RECV_HI: in_ready=1. On handshake, latch in_data as high byte.
    - in_last=1 → odd length: issue shift of {hi, 8'h00}, set error, → PAD.
    - Otherwise → RECV_LO.
  - RECV_LO: in_ready=1. On handshake, issue shift of {hi, in_data}.
    - in_last=1 → PAD.
    - Shift count reaches DEPTH without last → DRAIN.
    - Otherwise → RECV_HI.
  - PAD: in_ready=0. Issue PAD_WORD shift every cycle while word_count<DEPTH, then → DONE. Zero pad cycles if count already equals DEPTH.
  - DRAIN: in_ready=1. Accept and discard bytes; set error; no shifts. On in_last handshake → DONE.
  - DONE: done=1 for one cycle, busy←0 → IDLE.
- word_count increments on every shift_enable cycle and saturates at DEPTH; never exceeds DEPTH.
- If in_last arrives on the low byte of word DEPTH: no pad, no error, → DONE.
- rst mid-load: immediate return to reset values. IMEM shares rst, so a partial program is cleared.

## Timing
- Shift latency: shift_enable and new_value are registered. The pulse occurs the cycle after the completing byte handshake.
- Receive phase: at most one shift per two cycles.
- PAD phase: back-to-back one-cycle shifts.
- Input rules: in_valid gaps are allowed at any cycle; the block never drops a handshaked byte. in_ready depends only on state, with no combinational path from in_valid.
- done fires the cycle after the last pad shift, or the cycle after the in_last handshake in DRAIN.
- busy deasserts together with the done pulse. A start in that same cycle is ignored; start is accepted from the next cycle.
- Full 64-word load at full rate: 128 receive cycles + 1 + done.

## Structure
- Shared package imem_pkg holds:
  - IMEM_DEPTH=64, IMEM_WORD_W=16, IMEM_NOP=16'h0000.
  - loader state enum: IDLE, RECV_HI, RECV_LO, PAD, DRAIN, DONE.
  - IMEM and loader parameters default from these constants.
- Single module; no sub-module needed. FSM, byte latch, counter and output registers all live in imem_loader.

## Test plan
- Full load: start, 128 bytes 0x00..0x7F, last on 0x7F → 64 shifts, no pad, error=0, done once. IMEM[63]=16'h0001, IMEM[0]=16'h7E7F.
- Short program: 3 words 16'hA001, A002, A003 → 3 data shifts then 61 back-to-back PAD_WORD shifts. IMEM[63]=A001, IMEM[61]=A003, IMEM[60..0]=0, word_count=64.
- Odd length: 5 bytes 11 22 33 44 55 with last on 55 → third word 16'h5500, error=1, 61 pad shifts, done.
- Overflow: 65 words, last on byte 130 → exactly 64 shifts, bytes 129–130 accepted and discarded, error=1, done after last.
- Backpressure/gaps: random in_valid gaps and a start asserted mid-load → IMEM content identical to gap-free run; mid-load start has no effect.
- Reset mid-load: rst after 10 words → all outputs at reset values next edge. New start then loads correctly with error=0.
